mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one memory port between an instruction-fetch requester and a data
// (load/store) requester. The data side has priority. A streak counter stops
// fetch from starving: after MAX_STREAK data grants in a row while fetch was
// waiting, the next arbitration goes to fetch. Each access is bounded by a
// BUSY-cycle timer. If the timer expires, the access is abandoned and err
// pulses instead of done.
//
// Addresses and store data do not pass through this block. An external mux
// driven by mem_sel picks if_addr or d_addr, and d_wdata goes to memory
// directly. Those inputs appear here only so the port list is complete.
//
// Ports
//   clk        in   clock, all state changes on the rising edge
//   rst        in   asynchronous reset, active low
//   if_req     in   fetch request (held until if_done or err)
//   if_addr    in   fetch address (routed externally)
//   d_req      in   data request (held until d_done or err)
//   d_we       in   1 = store, 0 = load
//   d_addr     in   data address (routed externally)
//   d_wdata    in   store data (routed externally)
//   mem_req    out  memory access in progress
//   mem_sel    out  address mux select: 0 = if_addr, 1 = d_addr
//   mem_we     out  memory write enable
//   mem_ready  in   memory completion strobe, mem_rdata valid with it
//   mem_rdata  in   memory read data
//   if_done    out  one-cycle fetch completion pulse
//   d_done     out  one-cycle data completion pulse
//   rdata      out  registered read data, valid with if_done / d_done
//   if_stall   out  if_req & ~if_done
//   d_stall    out  d_req & ~d_done
//   err        out  one-cycle timeout pulse
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | no access; arbitrates unless a done/err pulse is showing
// BUSY_IF | fetch access on the memory port, waiting for mem_ready
// BUSY_D  | data access on the memory port, waiting for mem_ready
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MAX_STREAK = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          mem_req,
  output logic          mem_sel,
  output logic          mem_we,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic          if_done,
  output logic          d_done,
  output logic [DW-1:0] rdata,
  output logic          if_stall,
  output logic          d_stall,
  output logic          err
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUSY_IF = 2'd1;
  localparam logic [1:0] BUSY_D  = 2'd2;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);
  // Last BUSY cycle index before the access is abandoned.
  localparam logic [7:0] TCNT_LAST  = 8'(TIMEOUT - 1);

  logic [1:0]    state_q,   state_d;
  logic          sel_q,     sel_d;
  logic [DW-1:0] rdata_q,   rdata_d;
  logic          if_done_q, if_done_d;
  logic          d_done_q,  d_done_d;
  logic          err_q,     err_d;
  logic [3:0]    streak_q,  streak_d;
  logic [7:0]    tcnt_q,    tcnt_d;

  logic          pulse_cycle;
  logic          fetch_due;
  logic          grant_if;
  logic          grant_d;

  // Address and store-data inputs are consumed outside this block.
  logic unused_inputs;
  assign unused_inputs = ^{if_addr, d_addr, d_wdata};

  // No arbitration while a done/err pulse is visible. The finishing
  // requester still has its request up in that cycle and must not be
  // granted a second time.
  assign pulse_cycle = if_done_q | d_done_q | err_q;

  // Fetch wins a contested arbitration only when the streak has saturated.
  assign fetch_due = if_req & (~d_req | (streak_q == STREAK_MAX));

  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if ((state_q == IDLE) && !pulse_cycle) begin
      if (d_req && !fetch_due) begin
        grant_d = 1'b1;
      end else if (if_req) begin
        grant_if = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    rdata_d   = rdata_q;
    if_done_d = 1'b0;
    d_done_d  = 1'b0;
    err_d     = 1'b0;
    streak_d  = streak_q;
    tcnt_d    = tcnt_q;

    case (state_q)
      IDLE: begin
        // mem_ready in IDLE is deliberately ignored.
        if (grant_d) begin
          state_d = BUSY_D;
          sel_d   = 1'b1;
          tcnt_d  = 8'd0;
          // The streak only grows while fetch is actually waiting.
          if (!if_req) begin
            streak_d = 4'd0;
          end else if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + 4'd1;
          end
        end else if (grant_if) begin
          state_d  = BUSY_IF;
          sel_d    = 1'b0;
          tcnt_d   = 8'd0;
          streak_d = 4'd0;
        end
      end

      BUSY_IF, BUSY_D: begin
        if (mem_ready) begin
          // Stores also capture mem_rdata; the value is meaningless to them.
          rdata_d   = mem_rdata;
          state_d   = IDLE;
          if_done_d = (state_q == BUSY_IF);
          d_done_d  = (state_q == BUSY_D);
        end else if (tcnt_q == TCNT_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      sel_q     <= 1'b0;
      rdata_q   <= '0;
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      err_q     <= 1'b0;
      streak_q  <= 4'd0;
      tcnt_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      rdata_q   <= rdata_d;
      if_done_q <= if_done_d;
      d_done_q  <= d_done_d;
      err_q     <= err_d;
      streak_q  <= streak_d;
      tcnt_q    <= tcnt_d;
    end
  end

  // mem_sel keeps its last value in IDLE, so it comes straight from the
  // register that was loaded at grant time.
  assign mem_req  = (state_q != IDLE);
  assign mem_sel  = sel_q;
  assign mem_we   = (state_q == BUSY_D) & d_we;
  assign if_done  = if_done_q;
  assign d_done   = d_done_q;
  assign err      = err_q;
  assign rdata    = rdata_q;
  assign if_stall = if_req & ~if_done_q;
  assign d_stall  = d_req & ~d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int MS  = 4;
  localparam int TMO = 8;

  logic          clk;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          mem_req;
  logic          mem_sel;
  logic          mem_we;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;
  logic          if_done;
  logic          d_done;
  logic [DW-1:0] rdata;
  logic          if_stall;
  logic          d_stall;
  logic          err;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_STREAK(MS), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .mem_req(mem_req), .mem_sel(mem_sel), .mem_we(mem_we),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .if_done(if_done), .d_done(d_done), .rdata(rdata),
    .if_stall(if_stall), .d_stall(d_stall), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic        ir, dr, we, rdy;
    logic [31:0] rd;
    logic        e_req, e_sel, e_we, e_ifd, e_dd, e_err, e_ifs, e_ds;
    logic [31:0] e_rdata;
  } vec_t;

  function automatic vec_t mk(input logic ir, dr, we, rdy, input logic [31:0] rd,
                              input logic e_req, e_sel, e_we, e_ifd, e_dd, e_err,
                              input logic e_ifs, e_ds, input logic [31:0] e_rdata);
    vec_t v;
    v.ir = ir; v.dr = dr; v.we = we; v.rdy = rdy; v.rd = rd;
    v.e_req = e_req; v.e_sel = e_sel; v.e_we = e_we; v.e_ifd = e_ifd;
    v.e_dd = e_dd; v.e_err = e_err; v.e_ifs = e_ifs; v.e_ds = e_ds;
    v.e_rdata = e_rdata;
    return v;
  endfunction

  vec_t vecs[20];

  // ------------------------------------------------------------------ model
  // owner: 0 none, 1 fetch, 2 data; pulse: 0 none, 1 if_done, 2 d_done, 3 err
  int          m_owner, m_age, m_streak, m_pulse;
  logic        m_sel;
  logic [31:0] m_rdata;

  task automatic model_reset();
    m_owner = 0; m_age = 0; m_streak = 0; m_pulse = 0; m_sel = 1'b0; m_rdata = '0;
  endtask

  // Called at each rising edge, before the bench changes any input.
  task automatic model_edge();
    int  np;
    bit  fetch_first;
    np = 0;
    if (m_owner != 0) begin
      if (mem_ready) begin
        m_rdata = mem_rdata;
        np      = (m_owner == 1) ? 1 : 2;
        m_owner = 0;
      end else if (m_age + 1 == TMO) begin
        np      = 3;
        m_owner = 0;
      end else begin
        m_age++;
      end
    end else if (m_pulse == 0) begin
      fetch_first = if_req && (!d_req || m_streak == MS);
      if (d_req && !fetch_first) begin
        m_owner  = 2; m_sel = 1'b1; m_age = 0;
        m_streak = if_req ? ((m_streak + 1 > MS) ? MS : m_streak + 1) : 0;
      end else if (if_req) begin
        m_owner  = 1; m_sel = 1'b0; m_age = 0; m_streak = 0;
      end
    end
    m_pulse = np;
  endtask

  // ------------------------------------------------------------------ tests
  int          busy_cnt;
  bit          saw_err, saw_done;
  logic        err_stall;
  int          n_grants;
  logic        got[7];
  logic        exp_order[7];

  initial begin
    rst = 1'b0; if_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
    if_addr = 32'h40; d_addr = 32'h100; d_wdata = 32'hCAFE_0001; mem_rdata = '0;

    vecs[0]  = mk(0,0,0,0,32'h0,        0,0,0,0,0,0,0,0,32'h0);
    vecs[1]  = mk(0,0,0,1,32'hDEAD,     0,0,0,0,0,0,0,0,32'h0);
    vecs[2]  = mk(0,0,0,0,32'h0,        0,0,0,0,0,0,0,0,32'h0);
    vecs[3]  = mk(1,0,0,0,32'h0,        0,0,0,0,0,0,1,0,32'h0);
    vecs[4]  = mk(1,0,0,1,32'h13,       1,0,0,0,0,0,1,0,32'h0);
    vecs[5]  = mk(0,0,0,0,32'h0,        0,0,0,1,0,0,0,0,32'h13);
    vecs[6]  = mk(0,0,0,0,32'h0,        0,0,0,0,0,0,0,0,32'h13);
    vecs[7]  = mk(0,1,1,0,32'h0,        0,0,0,0,0,0,0,1,32'h13);
    vecs[8]  = mk(0,1,1,0,32'h0,        1,1,1,0,0,0,0,1,32'h13);
    vecs[9]  = mk(0,1,1,0,32'h0,        1,1,1,0,0,0,0,1,32'h13);
    vecs[10] = mk(0,1,1,1,32'hBEEF,     1,1,1,0,0,0,0,1,32'h13);
    vecs[11] = mk(0,0,0,0,32'h0,        0,1,0,0,1,0,0,0,32'hBEEF);
    vecs[12] = mk(0,0,0,0,32'h0,        0,1,0,0,0,0,0,0,32'hBEEF);
    vecs[13] = mk(1,1,0,0,32'h0,        0,1,0,0,0,0,1,1,32'hBEEF);
    vecs[14] = mk(1,1,0,1,32'h55,       1,1,0,0,0,0,1,1,32'hBEEF);
    vecs[15] = mk(1,0,0,0,32'h0,        0,1,0,0,1,0,1,0,32'h55);
    vecs[16] = mk(1,0,0,0,32'h0,        0,1,0,0,0,0,1,0,32'h55);
    vecs[17] = mk(1,0,0,1,32'h77,       1,0,0,0,0,0,1,0,32'h55);
    vecs[18] = mk(0,0,0,0,32'h0,        0,0,0,1,0,0,0,0,32'h77);
    vecs[19] = mk(0,0,0,0,32'h0,        0,0,0,0,0,0,0,0,32'h77);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Directed table: stray ready, single fetch, store, contested load, fetch.
    for (int i = 0; i < 20; i++) begin
      if_req = vecs[i].ir; d_req = vecs[i].dr; d_we = vecs[i].we;
      mem_ready = vecs[i].rdy; mem_rdata = vecs[i].rd;
      @(negedge clk);
      chk($sformatf("vec%0d_mem_req", i),  {31'b0, mem_req},  {31'b0, vecs[i].e_req});
      chk($sformatf("vec%0d_mem_sel", i),  {31'b0, mem_sel},  {31'b0, vecs[i].e_sel});
      chk($sformatf("vec%0d_mem_we", i),   {31'b0, mem_we},   {31'b0, vecs[i].e_we});
      chk($sformatf("vec%0d_if_done", i),  {31'b0, if_done},  {31'b0, vecs[i].e_ifd});
      chk($sformatf("vec%0d_d_done", i),   {31'b0, d_done},   {31'b0, vecs[i].e_dd});
      chk($sformatf("vec%0d_err", i),      {31'b0, err},      {31'b0, vecs[i].e_err});
      chk($sformatf("vec%0d_if_stall", i), {31'b0, if_stall}, {31'b0, vecs[i].e_ifs});
      chk($sformatf("vec%0d_d_stall", i),  {31'b0, d_stall},  {31'b0, vecs[i].e_ds});
      chk($sformatf("vec%0d_rdata", i),    rdata,             vecs[i].e_rdata);
      tick();
    end

    // Streak fairness: both requests held, memory answers every cycle.
    rst = 1'b0;
    tick();
    @(negedge clk);
    rst = 1'b1;
    tick();
    exp_order[0] = 1; exp_order[1] = 1; exp_order[2] = 1; exp_order[3] = 1;
    exp_order[4] = 0; exp_order[5] = 1; exp_order[6] = 1;
    if_req = 1; d_req = 1; d_we = 0; mem_ready = 1; mem_rdata = 32'hA5A5_0000;
    n_grants = 0;
    for (int c = 0; c < 60 && n_grants < 7; c++) begin
      @(negedge clk);
      if (mem_req) begin
        got[n_grants] = mem_sel;
        n_grants++;
      end
      tick();
    end
    chk("streak_grant_count", n_grants, 7);
    for (int g = 0; g < 7; g++)
      if (g < n_grants) chk($sformatf("streak_grant%0d_sel", g), {31'b0, got[g]}, {31'b0, exp_order[g]});
    if_req = 0; d_req = 0;
    repeat (4) tick();
    mem_ready = 0;
    repeat (2) tick();

    // Timeout on a store: memory never answers.
    d_req = 1; d_we = 1; d_addr = 32'h100;
    tick();
    busy_cnt = 0; saw_err = 0; saw_done = 0; err_stall = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (mem_req) busy_cnt++;
      if (if_done || d_done) saw_done = 1;
      if (err) begin
        saw_err   = 1;
        err_stall = d_stall;
        break;
      end
      tick();
    end
    chk("timeout_busy_cycles", busy_cnt, TMO);
    chk("timeout_err_seen", {31'b0, saw_err}, 32'd1);
    chk("timeout_no_done", {31'b0, saw_done}, 32'd0);
    chk("timeout_req_still_high", {31'b0, err_stall}, 32'd1);
    tick();
    tick();
    @(negedge clk);
    chk("regrant_after_err_req", {31'b0, mem_req}, 32'd1);
    chk("regrant_after_err_sel", {31'b0, mem_sel}, 32'd1);
    chk("regrant_after_err_we",  {31'b0, mem_we},  32'd1);

    // Asynchronous reset in the middle of that BUSY_D access.
    #2;
    rst = 1'b0;
    #1;
    chk("rst_async_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_async_mem_sel", {31'b0, mem_sel}, 32'd0);
    chk("rst_async_mem_we",  {31'b0, mem_we},  32'd0);
    chk("rst_async_done",    {30'b0, if_done, d_done}, 32'd0);
    chk("rst_async_err",     {31'b0, err},     32'd0);
    chk("rst_async_rdata",   rdata,            32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_regrant_req", {31'b0, mem_req}, 32'd1);
    chk("rst_regrant_sel", {31'b0, mem_sel}, 32'd1);
    mem_ready = 1; mem_rdata = 32'h1234_5678;
    tick();
    mem_ready = 0; d_req = 0; d_we = 0;
    @(negedge clk);
    chk("rst_regrant_d_done", {31'b0, d_done}, 32'd1);
    chk("rst_regrant_if_done", {31'b0, if_done}, 32'd0);
    chk("rst_regrant_rdata", rdata, 32'h1234_5678);

    // Randomised traffic against the reference model.
    rst = 1'b0; if_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    model_edge();
    #1;
    for (int c = 0; c < 3000; c++) begin
      if (m_pulse == 1) if_req = 0;
      else if (!if_req && $urandom_range(2) == 0) begin
        if_req = 1; if_addr = $urandom;
      end
      if (m_pulse == 2) d_req = 0;
      else if (!d_req && $urandom_range(2) == 0) begin
        d_req = 1; d_we = 1'($urandom_range(1)); d_addr = $urandom; d_wdata = $urandom;
      end
      mem_ready = ($urandom_range(9) < 3);
      mem_rdata = $urandom;
      @(negedge clk);
      chk("rnd_mem_req",  {31'b0, mem_req},  {31'b0, m_owner != 0});
      chk("rnd_mem_sel",  {31'b0, mem_sel},  {31'b0, m_sel});
      chk("rnd_mem_we",   {31'b0, mem_we},   {31'b0, (m_owner == 2) && d_we});
      chk("rnd_if_done",  {31'b0, if_done},  {31'b0, m_pulse == 1});
      chk("rnd_d_done",   {31'b0, d_done},   {31'b0, m_pulse == 2});
      chk("rnd_err",      {31'b0, err},      {31'b0, m_pulse == 3});
      chk("rnd_if_stall", {31'b0, if_stall}, {31'b0, if_req && (m_pulse != 1)});
      chk("rnd_d_stall",  {31'b0, d_stall},  {31'b0, d_req && (m_pulse != 2)});
      chk("rnd_rdata",    rdata,             m_rdata);
      @(posedge clk);
      model_edge();
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before the bench completed");
    $fatal(1);
  end

endmodule
